// File: rtl/rm_sym_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rm_sym_pkg
//  Purpose : Shared types and default constants for the runtime-monitor
//            symbol transmitter (FSM state encoding, symbol width, EOT code).
//  Rev     : 1.0  initial release
// ============================================================================
package rm_sym_pkg;

    // Transmitter session states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESET  = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } rm_tx_state_t;

    localparam int         RM_SYM_W   = 8;
    localparam logic [7:0] RM_EOT_SYM = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/rm_sym_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : rm_sym_fifo
//  Purpose : Synchronous single-clock FIFO holding event symbols between the
//            trace-tap handshake and the monitor output stage.
//  Ports   : clk, reset (async, active-high)
//            clear  - synchronous pointer/occupancy clear (wins over push/pop)
//            push   - write din at tail (ignored while full)
//            pop    - advance head (ignored while empty)
//            din    - symbol in
//            dout   - current head symbol (valid while !empty)
//            full   - occupancy == DEPTH
//            empty  - occupancy == 0
//  Rev     : 1.0  initial release
// ============================================================================
module rm_sym_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
    // One extra bit so that full and empty are distinct occupancy values
    logic [c_AW:0]   count_q, count_d;
    logic [W-1:0]    mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_q == (c_AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + c_AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + c_AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (c_AW+1)'(1);
                2'b01:   count_d = count_q - (c_AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed through count_q
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rm_symbol_tx.sv
`default_nettype none
// ============================================================================
//  Module  : rm_symbol_tx
//  Purpose : Symbol-stream transmitter feeding the runtime-monitor stage 0.
//            Buffers trace-tap events in a FIFO, sequences a monitor reset at
//            session start, streams one symbol per cycle and terminates the
//            session with an end-of-trace symbol.
//  Ports   : clk, reset (async, active-high)
//            start/stop          - session open/close pulses
//            ev_valid/ev_ready   - event handshake, ev_sym event symbol
//            top_symbols, run    - registered symbol + live flag to monitor
//            mon_reset           - registered monitor reset
//            busy                - session in progress (state != IDLE)
//            drop_count          - dropped-event counter (lossy build only)
//  Config  : RM_SYM_TX_LOSSY_EN  - when defined, no backpressure in STREAM;
//                                  events arriving while full are counted in
//                                  drop_count instead.
//  Rev     : 1.0  initial release
// ============================================================================
module rm_symbol_tx
    import rm_sym_pkg::*;
#(
    parameter int               SYM_W      = RM_SYM_W,
    parameter int               DEPTH      = 16,
    parameter int               RST_CYCLES = 4,
    parameter logic [SYM_W-1:0] EOT_SYM    = SYM_W'(RM_EOT_SYM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic [SYM_W-1:0] ev_sym,
    output logic [SYM_W-1:0] top_symbols,
    output logic             run,
    output logic             mon_reset,
    output logic             busy
`ifdef RM_SYM_TX_LOSSY_EN
    ,
    output logic [15:0]      drop_count
`endif
);

    localparam int c_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    rm_tx_state_t state_q, state_d;

    logic [c_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic               stop_pend_q, stop_pend_d;
    logic [SYM_W-1:0]   top_symbols_q, top_symbols_d;
    logic               run_q, run_d;
    logic               mon_reset_q, mon_reset_d;

    logic               fifo_clear;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [SYM_W-1:0]   fifo_head;
    logic               rst_cnt_zero;

    assign rst_cnt_zero = (rst_cnt_q == '0);

    rm_sym_fifo #(
        .W     (SYM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (ev_sym),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // start wins over a coincident stop
                if (start) state_d = ST_RESET;
            end
            ST_RESET: begin
                // A stop arriving on the final reset cycle counts as latched
                if (rst_cnt_zero) begin
                    state_d = (stop_pend_q || stop) ? ST_FLUSH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (stop) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Empty here means the EOT symbol goes out on this edge
                if (fifo_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
`ifdef RM_SYM_TX_LOSSY_EN
        ev_ready = (state_q == ST_STREAM);
`else
        ev_ready = (state_q == ST_STREAM) && !fifo_full;
`endif
        fifo_clear    = (state_q == ST_IDLE) && start;
        fifo_push     = ev_valid && ev_ready && !fifo_full;
        fifo_pop      = ((state_q == ST_STREAM) || (state_q == ST_FLUSH)) && !fifo_empty;

        top_symbols_d = top_symbols_q;
        run_d         = 1'b0;
        mon_reset_d   = 1'b0;
        rst_cnt_d     = rst_cnt_q;
        stop_pend_d   = stop_pend_q;

        if (fifo_pop) begin
            top_symbols_d = fifo_head;
            run_d         = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            top_symbols_d = EOT_SYM;
            run_d         = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mon_reset_d = 1'b1;
                    rst_cnt_d   = c_CNT_W'(RST_CYCLES - 1);
                    stop_pend_d = 1'b0;
                end
            end
            ST_RESET: begin
                if (stop) stop_pend_d = 1'b1;
                if (!rst_cnt_zero) begin
                    mon_reset_d = 1'b1;
                    rst_cnt_d   = rst_cnt_q - c_CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_cnt_q     <= '0;
            stop_pend_q   <= 1'b0;
            top_symbols_q <= '0;
            run_q         <= 1'b0;
            mon_reset_q   <= 1'b0;
        end else begin
            rst_cnt_q     <= rst_cnt_d;
            stop_pend_q   <= stop_pend_d;
            top_symbols_q <= top_symbols_d;
            run_q         <= run_d;
            mon_reset_q   <= mon_reset_d;
        end
    end

`ifdef RM_SYM_TX_LOSSY_EN
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if ((state_q == ST_IDLE) && start) begin
            drop_count_d = '0;
        end else if ((state_q == ST_STREAM) && ev_valid && fifo_full &&
                     (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    assign top_symbols = top_symbols_q;
    assign run         = run_q;
    assign mon_reset   = mon_reset_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/rm_symbol_tx.md
# rm_symbol_tx

Symbol-stream transmitter for the runtime-monitor automata stages. It accepts 8-bit event symbols from the core-side trace tap through a valid/ready handshake and buffers them in a small FIFO. It then drives the monitor's stage-0 inputs (`top_symbols`, `run`, `reset`) at one symbol per cycle. It sequences a monitor reset at session start and emits an end-of-trace symbol when the session ends.

## Interface
Parameters:
- `SYM_W`, 8: symbol width; matches the monitor's `top_symbols` width.
- `DEPTH`, 16: FIFO entries; must be a power of 2 and at least 2.
- `RST_CYCLES`, 4: number of cycles `mon_reset` is held at session start; at least 1.
- `EOT_SYM`, 8'hFF: terminator symbol emitted at session end.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: one-cycle pulse that opens a session.
- `stop`, in, 1: one-cycle pulse that closes a session.
- `ev_valid`, in, 1: event symbol is valid.
- `ev_ready`, out, 1: block accepts the event.
- `ev_sym`, in, `SYM_W`: event symbol.
- `top_symbols`, out, `SYM_W`: registered symbol to the monitor.
- `run`, out, 1: registered; the symbol on `top_symbols` is live this cycle.
- `mon_reset`, out, 1: registered reset to the monitor.
- `busy`, out, 1: state is not IDLE.
- `drop_count`, out, 16: present only with `RM_SYM_TX_LOSSY_EN`.

## Operation
- Reset values: state IDLE, FIFO empty, `top_symbols`=0, `run`=0, `mon_reset`=0, `ev_ready`=0, `busy`=0, `drop_count`=0.
- The block is a four-state FSM: IDLE, RESET, STREAM, FLUSH.
- IDLE:
  - `ev_ready`=0.
  - `start` moves the FSM to RESET and clears the FIFO pointers.
  - `stop` alone is ignored. If `start` and `stop` arrive in the same cycle, `start` wins and `stop` is dropped.
- RESET:
  - `mon_reset`=1 for exactly `RST_CYCLES` cycles, counted by a down-counter. `run`=0 and `ev_ready`=0.
  - The FSM then moves to STREAM.
  - A `stop` received during RESET is latched. In that case the FSM goes to FLUSH instead of STREAM.
- STREAM:
  - `ev_ready` = !full. A push happens when `ev_valid` && `ev_ready`.
  - Every cycle the FIFO is non-empty, the head is popped into `top_symbols` and `run`=1 on the next cycle.
  - When the FIFO is empty, `run`=0 and `top_symbols` holds its last value.
  - A push and a pop in the same cycle leave the occupancy unchanged.
  - A push while full is impossible (`ev_ready`=0), even if a pop happens that cycle.
- FLUSH (entered on `stop` in STREAM):
  - `ev_ready`=0. The FIFO drains at one symbol per cycle.
  - After the last pop, the next cycle drives `top_symbols`=`EOT_SYM` with `run`=1 for one cycle, then the FSM returns to IDLE.
  - `start` and `stop` are ignored during FLUSH.
- `start` received in RESET or STREAM is ignored.
- Pointers are log2(`DEPTH`) bits wide and wrap modulo `DEPTH`. Occupancy uses log2(`DEPTH`)+1 bits, giving distinct full and empty conditions.

## Timing
- Latency: an event accepted at edge N into an empty FIFO appears on `top_symbols` with `run`=1 after edge N+1.
- Sustained throughput is one symbol per cycle.
- The `start` pulse at edge N raises `mon_reset` after edge N. `mon_reset` falls after edge N+`RST_CYCLES`, and `ev_ready` can rise in that same cycle.
- `ev_ready` is combinational from the state and full flag only; it never depends on `ev_valid`.
- Asserting `reset` mid-session immediately forces all outputs to their reset values and discards FIFO contents. No EOT symbol is emitted.

## Configuration
- `RM_SYM_TX_LOSSY_EN` defined:
  - In STREAM, `ev_ready`=1 always.
  - An event presented while the FIFO is full is discarded and increments `drop_count`. The counter saturates at 16'hFFFF.
  - `drop_count` clears on `start`.
- `RM_SYM_TX_LOSSY_EN` undefined: the block applies backpressure as described above, and the `drop_count` port and its counter are absent.

## Structure
- Package `rm_sym_pkg` holds:
  - the FSM state enum `rm_tx_state_t`;
  - the default constants `RM_SYM_W`=8 and `RM_EOT_SYM`=8'hFF.
- Sub-module `rm_sym_fifo` is a synchronous single-clock FIFO with push/pop, full/empty and an async-reset pointer. The FSM, reset counter, output registers and drop counter sit in the top level.

## Test plan
- Basic stream: `start`, wait out 4 reset cycles, push 8'h11, 8'h22, 8'h33 back-to-back → `run`=1 for 3 consecutive cycles carrying 11, 22, 33, each 1 cycle after acceptance.
- Backpressure: with output draining, push 17 symbols in one burst with `DEPTH`=16 → `ev_ready` drops exactly when full, and all 17 symbols arrive in order with none lost.
- Flush: 5 symbols queued, then `stop` → all 5 are emitted, then 8'hFF with `run`=1 for one cycle, then `busy`=0.
- Boundaries: `stop` during RESET → after 4 `mon_reset` cycles only 8'hFF is emitted. `start`+`stop` together in IDLE → a session opens.
- Async reset in STREAM with 6 symbols queued → `run`=0, `top_symbols`=0, `mon_reset`=0 immediately, and no EOT symbol is emitted.
- Lossy mode (macro defined): 20 events pushed while output is stalled by a full FIFO → `drop_count`=4, and `drop_count` clears on the next `start`.
